// File: rtl/uart_tx_frame_engine.sv
// UART transmit frame engine: start bit, DATA_WIDTH data bits LSB-first, optional parity, 1 or 2 stop bits.
// Optional line-break generation is compiled in when UART_TX_BREAK_EN is defined (adds the send_break port).
module uart_tx_frame_engine #(
   parameter int   DATA_WIDTH = 8,
   parameter logic IDLE_LEVEL = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  bit_tick,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   input  logic                  par_en,
   input  logic                  par_typ,
   input  logic                  stop2,
`ifdef UART_TX_BREAK_EN
   input  logic                  send_break,
`endif
   output logic                  tx_out,
   output logic                  busy
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_WAIT_TICK,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP1,
      S_STOP2
`ifdef UART_TX_BREAK_EN
      ,
      S_BREAK,
      S_MARK
`endif
   } state_t;

   state_t                state_q, state_nxt;
   logic                  tx_q, tx_nxt;
   logic                  busy_q, busy_nxt;
   logic [DATA_WIDTH-1:0] shift_q, shift_nxt;
   logic [DATA_WIDTH-1:0] data_q, data_nxt;
   logic [CNT_W-1:0]      cnt_q, cnt_nxt;
   logic                  par_en_q, par_en_nxt;
   logic                  par_typ_q, par_typ_nxt;
   logic                  stop2_q, stop2_nxt;
   logic                  parity_bit;

   // Parity comes from the word captured at acceptance; the shift register is consumed as bits go out.
   assign parity_bit = (^data_q) ^ par_typ_q;

   // NOTE: every registered value is cleared by the async reset; sequential blocks use only non-blocking assignments.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         tx_q      <= IDLE_LEVEL;
         busy_q    <= 1'b0;
         shift_q   <= '0;
         data_q    <= '0;
         cnt_q     <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         stop2_q   <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         tx_q      <= tx_nxt;
         busy_q    <= busy_nxt;
         shift_q   <= shift_nxt;
         data_q    <= data_nxt;
         cnt_q     <= cnt_nxt;
         par_en_q  <= par_en_nxt;
         par_typ_q <= par_typ_nxt;
         stop2_q   <= stop2_nxt;
      end
   end

   // NOTE: all outputs of this block get a hold-value default first, so no path can infer a latch.
   always_comb begin
      state_nxt   = state_q;
      tx_nxt      = tx_q;
      busy_nxt    = busy_q;
      shift_nxt   = shift_q;
      data_nxt    = data_q;
      cnt_nxt     = cnt_q;
      par_en_nxt  = par_en_q;
      par_typ_nxt = par_typ_q;
      stop2_nxt   = stop2_q;

      unique case (state_q)
         S_IDLE: begin
`ifdef UART_TX_BREAK_EN
            // Break has priority over a simultaneous data request; that word is dropped.
            if (send_break) begin
               busy_nxt  = 1'b1;
               tx_nxt    = ~IDLE_LEVEL;
               state_nxt = S_BREAK;
            end else
`endif
            if (data_valid) begin
               shift_nxt   = p_data;
               data_nxt    = p_data;
               par_en_nxt  = par_en;
               par_typ_nxt = par_typ;
               stop2_nxt   = stop2;
               cnt_nxt     = '0;
               busy_nxt    = 1'b1;
               state_nxt   = S_WAIT_TICK;
            end
         end

         S_WAIT_TICK: begin
            if (bit_tick) begin
               tx_nxt    = ~IDLE_LEVEL;
               state_nxt = S_START;
            end
         end

         S_START: begin
            if (bit_tick) begin
               tx_nxt    = shift_q[0];
               shift_nxt = shift_q >> 1;
               cnt_nxt   = '0;
               state_nxt = S_DATA;
            end
         end

         S_DATA: begin
            // cnt_q is the index of the data bit currently on the line.
            if (bit_tick) begin
               if (cnt_q == LAST_BIT) begin
                  if (par_en_q) begin
                     tx_nxt    = parity_bit;
                     state_nxt = S_PARITY;
                  end else begin
                     tx_nxt    = IDLE_LEVEL;
                     state_nxt = S_STOP1;
                  end
               end else begin
                  tx_nxt    = shift_q[0];
                  shift_nxt = shift_q >> 1;
                  cnt_nxt   = cnt_q + CNT_W'(1);
               end
            end
         end

         S_PARITY: begin
            if (bit_tick) begin
               tx_nxt    = IDLE_LEVEL;
               state_nxt = S_STOP1;
            end
         end

         S_STOP1: begin
            if (bit_tick) begin
               if (stop2_q) begin
                  state_nxt = S_STOP2;
               end else begin
                  busy_nxt  = 1'b0;
                  state_nxt = S_IDLE;
               end
            end
         end

         S_STOP2: begin
            if (bit_tick) begin
               busy_nxt  = 1'b0;
               state_nxt = S_IDLE;
            end
         end

`ifdef UART_TX_BREAK_EN
         S_BREAK: begin
            if (bit_tick && !send_break) begin
               tx_nxt    = IDLE_LEVEL;
               state_nxt = S_MARK;
            end
         end

         S_MARK: begin
            if (bit_tick) begin
               busy_nxt  = 1'b0;
               state_nxt = S_IDLE;
            end
         end
`endif

         default: begin
            tx_nxt    = IDLE_LEVEL;
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign tx_out = tx_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Directed bench for uart_tx_frame_engine: an 8-bit and a 7-bit instance, bit_tick every 4 clocks.
// Break scenario is included when UART_TX_BREAK_EN is defined.
module tb_uart_tx_frame_engine;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       bit_tick = 1'b0;
   logic [7:0] p_data = 8'h00;
   logic       dv8 = 1'b0;
   logic       dv7 = 1'b0;
   logic       par_en = 1'b0;
   logic       par_typ = 1'b0;
   logic       stop2 = 1'b0;
`ifdef UART_TX_BREAK_EN
   logic       send_break = 1'b0;
`endif
   logic       tx8, busy8, tx7, busy7;

   int         checks = 0;
   int         failures = 0;
   int         tick_div = 0;
   logic [15:0] obs;
   logic       busy_ok;

   always #5 clk = ~clk;

   // One-clock bit_tick every fourth clock, changed on the falling edge.
   always @(negedge clk) begin
      tick_div = (tick_div + 1) % 4;
      bit_tick = (tick_div == 0);
   end

   uart_tx_frame_engine #(.DATA_WIDTH(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .bit_tick(bit_tick), .p_data(p_data),
      .data_valid(dv8), .par_en(par_en), .par_typ(par_typ), .stop2(stop2),
`ifdef UART_TX_BREAK_EN
      .send_break(send_break),
`endif
      .tx_out(tx8), .busy(busy8)
   );

   uart_tx_frame_engine #(.DATA_WIDTH(7)) dut7 (
      .clk(clk), .reset_n(reset_n), .bit_tick(bit_tick), .p_data(p_data[6:0]),
      .data_valid(dv7), .par_en(par_en), .par_typ(par_typ), .stop2(stop2),
`ifdef UART_TX_BREAK_EN
      .send_break(send_break),
`endif
      .tx_out(tx7), .busy(busy7)
   );

   task automatic wait_tick();
      int n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (!bit_tick && n < 20);
      if (!bit_tick) begin
         checks++;
         failures++;
         $display("FAIL tick_timeout: no bit_tick within %0d cycles", n);
      end
      #1;
   endtask

   task automatic capture(input bit sel, input int first, input int n);
      for (int i = first; i < first + n; i++) begin
         wait_tick();
         obs[i] = sel ? tx7 : tx8;
         if ((sel ? busy7 : busy8) !== 1'b1) busy_ok = 1'b0;
      end
   endtask

   task automatic start_frame(input bit sel, input string name);
      if (sel) dv7 = 1'b1; else dv8 = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ((sel ? busy7 : busy8) !== 1'b1 || (sel ? tx7 : tx8) !== 1'b1) begin
         failures++;
         $display("FAIL %s_accept: busy=%b tx=%b required busy=1 tx=1", name,
                  sel ? busy7 : busy8, sel ? tx7 : tx8);
      end
   endtask

   task automatic check_line(input int n, input logic [15:0] exp, input string name);
      logic [15:0] mask;
      mask = (16'h0001 << n) - 16'h0001;
      checks++;
      if ((obs & mask) !== exp) begin
         failures++;
         $display("FAIL %s_line: got %b required %b (%0d ticks, bit0 first)", name, obs & mask, exp, n);
      end
      checks++;
      if (busy_ok !== 1'b1) begin
         failures++;
         $display("FAIL %s_busy: busy dropped during frame, required 1 throughout", name);
      end
   endtask

   task automatic check_end(input bit sel, input string name);
      wait_tick();
      checks++;
      if ((sel ? busy7 : busy8) !== 1'b0 || (sel ? tx7 : tx8) !== 1'b1) begin
         failures++;
         $display("FAIL %s_end: busy=%b tx=%b required busy=0 tx=1", name,
                  sel ? busy7 : busy8, sel ? tx7 : tx8);
      end
   endtask

   task automatic run_frame(input bit sel, input int n, input logic [15:0] exp, input string name);
      obs = '0;
      busy_ok = 1'b1;
      start_frame(sel, name);
      dv7 = 1'b0;
      dv8 = 1'b0;
      capture(sel, 0, n);
      check_line(n, exp, name);
      check_end(sel, name);
   endtask

   task automatic test_reset();
      checks++;
      if (tx8 !== 1'b1 || busy8 !== 1'b0 || tx7 !== 1'b1 || busy7 !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: tx8=%b busy8=%b tx7=%b busy7=%b required 1 0 1 0", tx8, busy8, tx7, busy7);
      end
      @(negedge clk);
      reset_n = 1'b1;
      p_data = 8'h3C;
      par_en = 1'b0;
      obs = '0;
      busy_ok = 1'b1;
      start_frame(1'b0, "reset_pre");
      dv8 = 1'b0;
      capture(1'b0, 0, 4);
      #3;
      reset_n = 1'b0;
      #1;
      checks++;
      if (tx8 !== 1'b1 || busy8 !== 1'b0) begin
         failures++;
         $display("FAIL reset_async: tx=%b busy=%b required tx=1 busy=0", tx8, busy8);
      end
      @(negedge clk);
      reset_n = 1'b1;
      wait_tick();
      wait_tick();
      checks++;
      if (tx8 !== 1'b1 || busy8 !== 1'b0) begin
         failures++;
         $display("FAIL reset_no_resume: tx=%b busy=%b required tx=1 busy=0", tx8, busy8);
      end
   endtask

   task automatic test_parity();
      p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0;
      run_frame(1'b0, 11, {5'd0, 1'b1, 1'b0, 8'hA5, 1'b0}, "even_a5");
      p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b1;
      run_frame(1'b0, 12, {4'd0, 2'b11, 1'b1, 8'hA5, 1'b0}, "odd_a5_2stop");
      p_data = 8'h00; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b1;
      run_frame(1'b0, 12, {4'd0, 2'b11, 1'b0, 8'h00, 1'b0}, "even_00_2stop");
   endtask

   task automatic test_width7();
      p_data = 8'h55; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
      run_frame(1'b1, 9, {7'd0, 1'b1, 7'h55, 1'b0}, "w7_nopar");
      p_data = 8'h55; par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b0;
      run_frame(1'b1, 10, {6'd0, 1'b1, 1'b1, 7'h55, 1'b0}, "w7_odd");
   endtask

   task automatic test_back_to_back();
      logic idle_ok;
      p_data = 8'h01; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0;
      obs = '0;
      busy_ok = 1'b1;
      start_frame(1'b0, "b2b_first");
      capture(1'b0, 0, 3);
      p_data = 8'h80;
      par_en = 1'b0;
      capture(1'b0, 3, 8);
      check_line(11, {5'd0, 1'b1, 1'b1, 8'h01, 1'b0}, "b2b_first");
      check_end(1'b0, "b2b_first");
      @(posedge clk);
      #1;
      checks++;
      if (busy8 !== 1'b1) begin
         failures++;
         $display("FAIL b2b_reaccept: busy=%b required 1", busy8);
      end
      dv8 = 1'b0;
      obs = '0;
      busy_ok = 1'b1;
      capture(1'b0, 0, 4);
      p_data = 8'hFF;
      dv8 = 1'b1;
      @(posedge clk);
      #1;
      dv8 = 1'b0;
      capture(1'b0, 4, 6);
      check_line(10, {6'd0, 1'b1, 8'h80, 1'b0}, "b2b_second");
      check_end(1'b0, "b2b_second");
      idle_ok = 1'b1;
      repeat (4) begin
         wait_tick();
         if (tx8 !== 1'b1 || busy8 !== 1'b0) idle_ok = 1'b0;
      end
      checks++;
      if (idle_ok !== 1'b1) begin
         failures++;
         $display("FAIL busy_drop: got activity after frame, required tx=1 busy=0 (pulse not queued)");
      end
   endtask

`ifdef UART_TX_BREAK_EN
   task automatic test_break();
      logic low_ok;
      logic idle_ok;
      p_data = 8'hC3; par_en = 1'b0; stop2 = 1'b0;
      send_break = 1'b1;
      dv8 = 1'b1;
      @(posedge clk);
      #1;
      dv8 = 1'b0;
      checks++;
      if (busy8 !== 1'b1 || tx8 !== 1'b0) begin
         failures++;
         $display("FAIL break_start: busy=%b tx=%b required busy=1 tx=0", busy8, tx8);
      end
      low_ok = 1'b1;
      repeat (19) begin
         wait_tick();
         if (tx8 !== 1'b0 || busy8 !== 1'b1) low_ok = 1'b0;
      end
      checks++;
      if (low_ok !== 1'b1) begin
         failures++;
         $display("FAIL break_hold: line left break early, required tx=0 busy=1");
      end
      send_break = 1'b0;
      wait_tick();
      checks++;
      if (tx8 !== 1'b1 || busy8 !== 1'b1) begin
         failures++;
         $display("FAIL break_mark: tx=%b busy=%b required tx=1 busy=1", tx8, busy8);
      end
      check_end(1'b0, "break");
      idle_ok = 1'b1;
      repeat (12) begin
         wait_tick();
         if (tx8 !== 1'b1 || busy8 !== 1'b0) idle_ok = 1'b0;
      end
      checks++;
      if (idle_ok !== 1'b1) begin
         failures++;
         $display("FAIL break_data_dropped: frame sent after break, required idle line");
      end
   endtask
`endif

   initial begin
      #12;
      test_reset();
      test_parity();
      test_width7();
      test_back_to_back();
`ifdef UART_TX_BREAK_EN
      test_break();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
